// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths and FSM state encoding for the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int ADDR_W  = 15;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_ir.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ir
// Description : Instruction register. Holds the instruction word, its
//               address and a valid flag. Load and clear are mutually
//               exclusive from the controlling FSM; load takes priority.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ir
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;

  // Next-value: capture word and address on load, drop only the valid flag on clear.
  always_comb begin
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    if (load) begin
      instr_d    = load_instr;
      instr_pc_d = load_pc;
      valid_d    = 1'b1;
    end else if (clear) begin
      valid_d    = 1'b0;
    end
  end

  // Register bank, cleared asynchronously to all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding-request instruction fetcher. Reads one
//               word per request from instruction memory, presents it to
//               decode, asks the PC stage to increment on every accepted
//               word and to load on every branch redirect. Requests already
//               issued when a redirect arrives are drained and discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_inc,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_load_val,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_req,
  input  logic [ADDR_W-1:0]  branch_target
);

  fetch_state_e      state_q, state_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              ir_load;
  logic              ir_clear;
  logic              pc_inc_w;
  logic              mem_req_w;

  // Next-state and handshake decode. armed_q delays the very first IDLE->FETCH
  // by one cycle after reset release so the PC stage has settled.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    armed_d    = 1'b1;
    ir_load    = 1'b0;
    ir_clear   = 1'b0;
    pc_inc_w   = 1'b0;
    mem_req_w  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!branch_req && armed_q) begin
          state_d    = FETCH;
          mem_addr_d = pc_addr;
        end
      end
      FETCH: begin
        mem_req_w = 1'b1;
        if (branch_req) begin
          // Redirect wins: an ack in the same cycle is simply dropped.
          state_d = mem_ack ? IDLE : DRAIN;
        end else if (mem_ack) begin
          ir_load  = 1'b1;
          pc_inc_w = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (branch_req) begin
          ir_clear = 1'b1;
          state_d  = IDLE;
        end else if (instr_ready) begin
          ir_clear   = 1'b1;
          state_d    = FETCH;
          mem_addr_d = pc_addr;
        end
      end
      DRAIN: begin
        // Wait out the abandoned request; its data is never loaded.
        mem_req_w = 1'b1;
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, start-up flag and registered memory address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  fetch_ir u_ir (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ir_load),
    .clear      (ir_clear),
    .load_instr (mem_rdata),
    .load_pc    (mem_addr_q),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid)
  );

  // pc_load follows branch_req directly; gated so reset forces it low.
  assign pc_load     = branch_req & rst_n;
  assign pc_load_val = rst_n ? branch_target : '0;
  assign pc_inc      = pc_inc_w;
  assign mem_req     = mem_req_w;
  assign mem_addr    = mem_addr_q;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port pc_addr, input, 15, current program counter from the PC stage.
REQ-004 SHALL have port pc_inc, output, 1, one-cycle pulse requesting PC increment.
REQ-005 SHALL have port pc_load, output, 1, one-cycle pulse requesting PC load.
REQ-006 SHALL have port pc_load_val, output, 15, target for pc_load.
REQ-007 SHALL have port mem_req, output, 1, instruction memory read request.
REQ-008 SHALL have port mem_addr, output, 15, read address, registered.
REQ-009 SHALL have port mem_ack, input, 1, memory read data valid.
REQ-010 SHALL have port mem_rdata, input, 16, instruction word.
REQ-011 SHALL have port instr, output, 16, latched instruction to decode.
REQ-012 SHALL have port instr_pc, output, 15, address of instr.
REQ-013 SHALL have port instr_valid, output, 1, instr/instr_pc valid.
REQ-014 SHALL have port instr_ready, input, 1, decode accepts instr.
REQ-015 SHALL have port branch_req, input, 1, redirect request, one cycle.
REQ-016 SHALL have port branch_target, input, 15, redirect address.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, HOLD, DRAIN.
REQ-018 IDLE: all handshakes low; next cycle -> FETCH unless branch_req.
REQ-019 On every IDLE->FETCH and HOLD->FETCH transition, mem_addr SHALL capture pc_addr.
REQ-020 FETCH: mem_req=1, mem_addr stable until mem_ack; no timeout.
REQ-021 FETCH with mem_ack and no branch_req: instr<=mem_rdata, instr_pc<=mem_addr, instr_valid<=1, pc_inc pulsed that cycle, -> HOLD.
REQ-022 HOLD: instr_valid=1, instr/instr_pc stable; instr_ready high -> instr_valid cleared, -> FETCH (capturing pc_addr already incremented).
REQ-023 Steady-state throughput with instr_ready tied high and 1-cycle mem_ack: one instruction per 3 cycles; mem_rdata to instr_valid latency 1 cycle.
REQ-024 branch_req in any state SHALL pulse pc_load for exactly that cycle with pc_load_val=branch_target; branch_req has priority over mem_ack and instr_ready.
REQ-025 branch_req in IDLE: stay IDLE one more cycle (PC settles), then FETCH.
REQ-026 branch_req in FETCH without mem_ack: -> DRAIN; mem_req stays high, mem_addr unchanged.
REQ-027 branch_req in FETCH with mem_ack same cycle: data discarded, no pc_inc, -> IDLE.
REQ-028 DRAIN: hold mem_req until mem_ack, discard data, no pc_inc, -> IDLE; further branch_req re-pulses pc_load, stays DRAIN.
REQ-029 branch_req in HOLD: instr_valid cleared next edge regardless of instr_ready, -> IDLE.
REQ-030 pc_inc and pc_load SHALL never be high in the same cycle.
REQ-031 No address arithmetic in this block; 0x7FFF wrap is owned by the PC stage; instr_pc=0x7FFF is legal.

Reset
REQ-032 rst_n low SHALL force IDLE and all outputs to 0 (instr=16'h0000, instr_pc=15'h0000, mem_addr=15'h0000) asynchronously.
REQ-033 Reset mid-FETCH SHALL drop mem_req immediately; memory side tolerates abandoned request.
REQ-034 First mem_req SHALL assert on the second rising edge after rst_n deasserts.

Structure
REQ-035 Package fetch_pkg SHALL hold ADDR_W=15, INSTR_W=16 and the FSM state enum.
REQ-036 Sub-module fetch_ir SHALL hold instr, instr_pc, instr_valid with load/clear controls; the FSM stays in fetch_unit.

Verification
REQ-037 Reset release, pc_addr=5, mem_ack 1 cycle later with 16'hA5A5 -> instr=A5A5, instr_pc=5, instr_valid=1, one pc_inc pulse.
REQ-038 instr_ready low for 4 cycles in HOLD -> instr_valid/instr stable, no mem_req, no pc_inc.
REQ-039 branch_req target=0x0100 while FETCH awaiting ack (ack 3 cycles later) -> pc_load one cycle with 0x0100, DRAIN, data discarded, next mem_addr=0x0100.
REQ-040 branch_req and mem_ack same cycle -> no pc_inc, instr_valid stays 0, pc_load once.
REQ-041 pc_addr=0x7FFF fetch -> instr_pc=0x7FFF, pc_inc pulsed; next mem_addr follows PC value 0x0000.
REQ-042 rst_n low during FETCH -> mem_req, instr_valid low immediately; normal fetch resumes after release.
